// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage data-memory access unit. Converts one load or store per
// instruction into a single request/acknowledge transaction on a word-wide
// data bus. Stores get byte-lane steering and write strobes; loads get
// byte/halfword extraction with sign or zero extension. The pipeline is
// stalled while a transaction is outstanding. Misaligned accesses raise
// misalign_exc and generate no bus traffic; a bus that never acknowledges
// is abandoned after TIMEOUT_CYCLES and reported on bus_err.
//
// Parameters
//   TIMEOUT_CYCLES  max BUSY cycles without bus_ack before abort (0 = never)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mem_valid_in    a valid instruction occupies the MEM stage
//   mem_write       instruction is a store
//   wb_load         instruction is a load
//   mem_load_type   load type code (LOAD_*)
//   mem_store_type  store type code (STORE_*)
//   addr            byte address from the ALU
//   store_data      rs2 value
//   mem_stall       freezes IF..MEM
//   load_data       extended load result (registered)
//   load_valid      one-cycle pulse, load_data valid
//   misalign_exc    misaligned request seen in IDLE
//   bus_err         one-cycle pulse on timeout abort
//   bus_req/we/addr/wstrb/wdata   bus request side
//   bus_rdata/ack                 bus response side
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_in,
    input  logic        mem_write,
    input  logic        wb_load,
    input  logic [2:0]  mem_load_type,
    input  logic [1:0]  mem_store_type,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    // Decoder type codes (kept in step with the decode stage).
    localparam logic [2:0] LOAD_LB   = 3'd0;
    localparam logic [2:0] LOAD_HD   = 3'd1;
    localparam logic [2:0] LOAD_LW   = 3'd2;
    localparam logic [2:0] LOAD_LBU  = 3'd3;
    localparam logic [2:0] LOAD_LHU  = 3'd4;
    localparam logic [2:0] LOAD_DEF  = 3'd5;

    localparam logic [1:0] STORE_SB  = 2'd0;
    localparam logic [1:0] STORE_SH  = 2'd1;
    localparam logic [1:0] STORE_SW  = 2'd2;
    localparam logic [1:0] STORE_DEF = 2'd3;

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_wstrb;
    logic           r_we;
    logic [2:0]     r_ltype;
    logic [1:0]     r_off;
    logic           r_is_load;
    logic           r_err;
    logic [31:0]    r_load_data;
    logic [CNT_W-1:0] r_cnt;

    logic           w_is_load;
    logic           w_is_store;
    logic           w_req;
    logic           w_aligned;
    logic [3:0]     w_wstrb;
    logic [31:0]    w_wdata;
    logic           w_accept;
    logic           w_timeout;

    // Byte/halfword extraction and extension of a read word.
    function automatic logic [31:0] format_load(
        input logic [2:0]  ltype,
        input logic [1:0]  off,
        input logic [31:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (ltype)
            LOAD_LB:  return {{24{b[7]}}, b};
            LOAD_LBU: return {24'b0, b};
            LOAD_HD:  return {{16{h[15]}}, h};
            LOAD_LHU: return {16'b0, h};
            default:  return word;      // LOAD_LW, LOAD_DEF
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Request decode: alignment and store lane steering
    // -----------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default at the top
    // so no path leaves it unassigned; otherwise a latch is inferred.
    always_comb begin
        w_is_load  = wb_load;
        w_is_store = mem_write && (mem_store_type != STORE_DEF);
        w_req      = mem_valid_in && (w_is_load || w_is_store);
        w_aligned  = 1'b1;
        w_wstrb    = 4'b0000;
        w_wdata    = 32'b0;
        if (w_is_load) begin
            case (mem_load_type)
                LOAD_LB, LOAD_LBU: w_aligned = 1'b1;
                LOAD_HD, LOAD_LHU: w_aligned = ~addr[0];
                default:           w_aligned = (addr[1:0] == 2'b00);
            endcase
        end else begin
            case (mem_store_type)
                STORE_SB: begin
                    w_wstrb = 4'b0001 << addr[1:0];
                    w_wdata = {4{store_data[7:0]}};
                end
                STORE_SH: begin
                    w_aligned = ~addr[0];
                    w_wstrb   = addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata   = {2{store_data[15:0]}};
                end
                default: begin          // STORE_SW (STORE_DEF never requests)
                    w_aligned = (addr[1:0] == 2'b00);
                    w_wstrb   = 4'b1111;
                    w_wdata   = store_data;
                end
            endcase
        end
    end

    // Counter holds the number of un-acked BUSY cycles already spent, so the
    // current cycle is the last allowed one when it equals TIMEOUT_CYCLES-1.
    assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        mem_stall    = 1'b0;
        misalign_exc = 1'b0;
        bus_req      = 1'b0;
        load_valid   = 1'b0;
        bus_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_aligned) begin
                        w_accept  = 1'b1;
                        mem_stall = 1'b1;
                        w_next    = S_BUSY;
                    end else begin
                        misalign_exc = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                bus_req   = 1'b1;
                mem_stall = 1'b1;
                if (bus_ack || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                // The instruction still in MEM here is the one just served;
                // it is never re-accepted.
                load_valid = r_is_load && !r_err;
                bus_err    = r_err;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Transaction registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= 32'b0;
            r_wdata     <= 32'b0;
            r_wstrb     <= 4'b0;
            r_we        <= 1'b0;
            r_ltype     <= 3'b0;
            r_off       <= 2'b0;
            r_is_load   <= 1'b0;
            r_err       <= 1'b0;
            r_load_data <= 32'b0;
            r_cnt       <= '0;
        end else begin
            if (w_accept) begin
                r_addr    <= {addr[31:2], 2'b00};
                r_we      <= !w_is_load;
                r_wstrb   <= w_is_load ? 4'b0000 : w_wstrb;
                r_wdata   <= w_is_load ? 32'b0 : w_wdata;
                r_ltype   <= mem_load_type;
                r_off     <= addr[1:0];
                r_is_load <= w_is_load;
                r_err     <= 1'b0;
                r_cnt     <= '0;
            end
            if (r_state == S_BUSY) begin
                if (bus_ack) begin
                    if (r_is_load) begin
                        r_load_data <= format_load(r_ltype, r_off, bus_rdata);
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign load_data = r_load_data;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wstrb = r_wstrb;
    assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed scenarios followed by randomized accesses. Expected bus lanes,
// strobes, load results and cycle counts come from a byte-level model of
// the access rules (lane ranges, shifts, two's-complement extension).
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int TO = 4;

    localparam logic [2:0] LOAD_LB   = 3'd0;
    localparam logic [2:0] LOAD_HD   = 3'd1;
    localparam logic [2:0] LOAD_LW   = 3'd2;
    localparam logic [2:0] LOAD_LBU  = 3'd3;
    localparam logic [2:0] LOAD_LHU  = 3'd4;
    localparam logic [2:0] LOAD_DEF  = 3'd5;
    localparam logic [1:0] STORE_SB  = 2'd0;
    localparam logic [1:0] STORE_SH  = 2'd1;
    localparam logic [1:0] STORE_SW  = 2'd2;
    localparam logic [1:0] STORE_DEF = 2'd3;

    typedef enum int {K_LB, K_HD, K_LW, K_LBU, K_LHU, K_LDEF, K_SB, K_SH, K_SW, K_NOP} kind_t;

    typedef struct {
        kind_t       kind;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          waits;     // ack in this BUSY cycle index; >= TO never acks in time
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid_in = 1'b0;
    logic        mem_write = 1'b0;
    logic        wb_load = 1'b0;
    logic [2:0]  mem_load_type = 3'd0;
    logic [1:0]  mem_store_type = STORE_DEF;
    logic [31:0] addr = 32'b0;
    logic [31:0] store_data = 32'b0;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign_exc;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'b0;
    logic        bus_ack = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          txn_id = 0;
    logic [31:0] model_ld = 32'b0;     // value load_data must hold

    // Results of the most recent access, for the literal directed checks.
    int          last_stall, last_req, last_lv, last_err, last_mis;
    logic [31:0] last_addr, last_wdata, last_ld;
    logic [3:0]  last_wstrb;
    logic        last_we;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid_in   (mem_valid_in),
        .mem_write      (mem_write),
        .wb_load        (wb_load),
        .mem_load_type  (mem_load_type),
        .mem_store_type (mem_store_type),
        .addr           (addr),
        .store_data     (store_data),
        .mem_stall      (mem_stall),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .misalign_exc   (misalign_exc),
        .bus_err        (bus_err),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wstrb      (bus_wstrb),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .bus_ack        (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_load(kind_t k);
        return k inside {K_LB, K_HD, K_LW, K_LBU, K_LHU, K_LDEF};
    endfunction

    function automatic bit is_store(kind_t k);
        return k inside {K_SB, K_SH, K_SW};
    endfunction

    function automatic int size_of(kind_t k);
        case (k)
            K_LB, K_LBU, K_SB: return 1;
            K_HD, K_LHU, K_SH: return 2;
            default:           return 4;
        endcase
    endfunction

    // Lanes touched are [offset, offset+size).
    function automatic logic [3:0] model_wstrb(kind_t k, logic [31:0] a);
        logic [3:0] s = 4'b0;
        int off = int'(a[1:0]);
        for (int lane = 0; lane < 4; lane++)
            if (lane >= off && lane < off + size_of(k)) s[lane] = 1'b1;
        return s;
    endfunction

    // Each lane carries the store byte at (lane mod size).
    function automatic logic [31:0] model_wdata(kind_t k, logic [31:0] sd);
        logic [31:0] d;
        for (int lane = 0; lane < 4; lane++)
            d[8*lane +: 8] = sd[8*(lane % size_of(k)) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] model_load(kind_t k, logic [31:0] a, logic [31:0] rd);
        int     sz  = size_of(k);
        int     off = int'(a[1:0]);
        longint v;
        v = longint'(rd >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
        if ((k == K_LB || k == K_HD) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input txn_t t);
        mem_valid_in   = 1'b1;
        wb_load        = is_load(t.kind);
        mem_write      = is_store(t.kind) || (t.kind == K_NOP && $urandom_range(0, 1) == 1);
        addr           = t.addr;
        store_data     = t.sd;
        mem_load_type  = 3'($urandom_range(0, 7));
        mem_store_type = 2'($urandom_range(0, 3));
        case (t.kind)
            K_LB:   mem_load_type = LOAD_LB;
            K_HD:   mem_load_type = LOAD_HD;
            K_LW:   mem_load_type = LOAD_LW;
            K_LBU:  mem_load_type = LOAD_LBU;
            K_LHU:  mem_load_type = LOAD_LHU;
            K_LDEF: mem_load_type = LOAD_DEF;
            K_SB:   mem_store_type = STORE_SB;
            K_SH:   mem_store_type = STORE_SH;
            K_SW:   mem_store_type = STORE_SW;
            default: mem_store_type = STORE_DEF;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mem_valid_in = 1'b0;
            bus_ack      = 1'b0;
        end
    endtask

    // Present one instruction, hold it while stalled, serve the bus, check.
    task automatic access(input txn_t t);
        bit          ld = is_load(t.kind);
        bit          st = is_store(t.kind);
        bit          ok_align = (int'(t.addr[1:0]) % size_of(t.kind)) == 0;
        bit          accepted = (ld || st) && ok_align;
        bit          success = accepted && (t.waits < TO);
        int          exp_stall = accepted ? (1 + (success ? t.waits + 1 : TO)) : 0;
        int          stall_n = 0, req_n = 0, lv_n = 0, err_n = 0, mis_n = 0, busy_idx = 0;
        bit          first_busy = 1'b1, stable = 1'b1, done = 1'b0;
        logic        req0 = 1'b0;
        logic [31:0] b_addr = 32'b0, b_wdata = 32'b0, ld_seen = 32'b0;
        logic [3:0]  b_wstrb = 4'b0;
        logic        b_we = 1'b0;
        string       id;
        txn_id++;
        id = $sformatf("t%0d", txn_id);
        @(negedge clk);
        drive(t);
        bus_ack = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c == 0) req0 = bus_req;
            if (mem_stall) stall_n++;
            if (misalign_exc) mis_n++;
            if (load_valid) lv_n++;
            if (bus_err) err_n++;
            if (bus_req) begin
                req_n++;
                if (first_busy) begin
                    b_addr = bus_addr; b_we = bus_we; b_wstrb = bus_wstrb; b_wdata = bus_wdata;
                    first_busy = 1'b0;
                end else if ({bus_addr, bus_we, bus_wstrb, bus_wdata} !== {b_addr, b_we, b_wstrb, b_wdata}) begin
                    stable = 1'b0;
                end
                bus_ack   = (busy_idx == t.waits);
                bus_rdata = bus_ack ? t.rdata : $urandom;
                busy_idx++;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = $urandom;
            end
            if (!mem_stall && (accepted ? (c > 0) : (c == 2))) begin
                done    = 1'b1;
                ld_seen = load_data;
            end
        end
        if (ld && success) model_ld = model_load(t.kind, t.addr, t.rdata);
        chk({id, "_finished"},  32'(done), 32'd1);
        chk({id, "_req_at_accept"}, 32'(req0), 32'd0);
        chk({id, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
        chk({id, "_req_cycles"}, 32'(req_n), 32'(accepted ? exp_stall - 1 : 0));
        chk({id, "_load_valid"}, 32'(lv_n), 32'(ld && success));
        chk({id, "_bus_err"}, 32'(err_n), 32'(accepted && !success));
        chk({id, "_misalign"}, 32'(mis_n), 32'(((ld || st) && !ok_align) ? 3 : 0));
        if (accepted) begin
            chk({id, "_bus_addr"}, b_addr, {t.addr[31:2], 2'b00});
            chk({id, "_bus_we"}, 32'(b_we), 32'(st));
            chk({id, "_bus_wstrb"}, 32'(b_wstrb), 32'(st ? model_wstrb(t.kind, t.addr) : 4'b0));
            if (st) chk({id, "_bus_wdata"}, b_wdata, model_wdata(t.kind, t.sd));
            chk({id, "_bus_stable"}, 32'(stable), 32'd1);
            chk({id, "_load_data"}, ld_seen, model_ld);
        end
        last_stall = stall_n; last_req = req_n; last_lv = lv_n; last_err = err_n; last_mis = mis_n;
        last_addr = b_addr; last_wdata = b_wdata; last_wstrb = b_wstrb; last_we = b_we; last_ld = ld_seen;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        txn_t t;
        int   lv_n, err_n;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_bus_req",   32'(bus_req), 32'd0);
        chk("rst_bus_we",    32'(bus_we), 32'd0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        chk("rst_bus_addr",  bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_load_valid", 32'(load_valid), 32'd0);
        chk("rst_bus_err",   32'(bus_err), 32'd0);
        chk("rst_mem_stall", 32'(mem_stall), 32'd0);
        rst = 1'b0;
        idle(1);

        // SB with byte lane 3
        t = '{K_SB, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0};
        access(t);
        chk("sb_addr",  last_addr, 32'h0000_1000);
        chk("sb_wstrb", 32'(last_wstrb), 32'h8);
        chk("sb_wdata", last_wdata, 32'hDDDD_DDDD);
        chk("sb_stall", 32'(last_stall), 32'd2);

        // LB then LBU back to back
        t = '{K_LB, 32'h0000_2002, 32'h0, 32'h00F3_0000, 0};
        access(t);
        chk("lb_data", last_ld, 32'hFFFF_FFF3);
        t.kind = K_LBU;
        access(t);
        chk("lbu_data", last_ld, 32'h0000_00F3);

        // HD with 3 wait states: ack lands on the last cycle before timeout
        t = '{K_HD, 32'h0000_2006, 32'h0, 32'h8001_0000, 3};
        access(t);
        chk("hd_data",  last_ld, 32'hFFFF_8001);
        chk("hd_stall", 32'(last_stall), 32'd5);
        chk("hd_req",   32'(last_req), 32'd4);

        // Misaligned LW
        idle(1);
        t = '{K_LW, 32'h0000_3001, 32'h0, 32'h1234_5678, 0};
        access(t);
        chk("mis_req", 32'(last_req), 32'd0);

        // Timeout
        idle(1);
        t = '{K_LW, 32'h0000_3000, 32'h0, 32'h1234_5678, 99};
        access(t);
        chk("to_req", 32'(last_req), 32'd4);
        chk("to_err", 32'(last_err), 32'd1);
        chk("to_lv",  32'(last_lv), 32'd0);

        // Reset while BUSY
        idle(1);
        t = '{K_LW, 32'h0000_5000, 32'h0, 32'h0, 99};
        @(negedge clk);
        drive(t);
        bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_rst_pre_req", 32'(bus_req), 32'd1);
        rst = 1'b1;
        mem_valid_in = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_req",   32'(bus_req), 32'd0);
        chk("mid_rst_stall", 32'(mem_stall), 32'd0);
        chk("mid_rst_ld",    load_data, 32'd0);
        model_ld = 32'b0;
        rst = 1'b0;
        lv_n = 0;
        err_n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (load_valid) lv_n++;
            if (bus_err) err_n++;
        end
        chk("mid_rst_no_pulses", 32'(lv_n + err_n), 32'd0);
        t = '{K_SW, 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 1};
        access(t);
        chk("sw_wstrb", 32'(last_wstrb), 32'hF);
        chk("sw_wdata", last_wdata, 32'hCAFE_F00D);
        chk("sw_we",    32'(last_we), 32'd1);

        // Non-memory instruction in MEM
        t = '{K_NOP, 32'h0000_6003, 32'h0, 32'h0, 0};
        access(t);

        // Randomized accesses, sometimes back to back
        for (int n = 0; n < 60; n++) begin
            t.kind  = kind_t'($urandom_range(0, 9));
            t.addr  = $urandom;
            t.sd    = $urandom;
            t.rdata = $urandom;
            t.waits = $urandom_range(0, 5);
            access(t);
            if ($urandom_range(0, 1) == 1) idle(1);
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
